avmm_wr_arbiter: RTL and testbench

Two-requester, write-only Avalon-MM arbiter that shares one downstream write master between the Rdmap queue-pair writer (requester 0) and the doorbell/arbitration writer (requester 1).
- Sits between the RDMAP engine and the PCIe DMA write interface.
- Round-robin arbitration with a bounded hold so back-to-back writes from one requester cannot starve the other.

---
 rtl/avmm_wr_arbiter.sv | 152 +++++++++++++++
 tb/tb_avmm_wr_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_wr_arbiter.sv
// Two-requester write-only Avalon-MM arbiter: round-robin with bounded hold.
// Optional build macro ARB_STATS_EN adds stat0/stat1/stall counters.
module avmm_wr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   r0Address,
  input  logic [DATA_W/8-1:0] r0ByteEnable,
  input  logic                r0ChipSelect,
  input  logic                r0Write,
  input  logic [DATA_W-1:0]   r0WriteData,
  output logic                r0WaitRequest,
  input  logic [ADDR_W-1:0]   r1Address,
  input  logic [DATA_W/8-1:0] r1ByteEnable,
  input  logic                r1ChipSelect,
  input  logic                r1Write,
  input  logic [DATA_W-1:0]   r1WriteData,
  output logic                r1WaitRequest,
  output logic [ADDR_W-1:0]   mAddress,
  output logic [DATA_W/8-1:0] mByteEnable,
  output logic                mChipSelect,
  output logic                mWrite,
  output logic [DATA_W-1:0]   mWriteData,
  input  logic                mWaitRequest,
  output logic [1:0]          grant
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]         stat0,
  output logic [31:0]         stat1,
  output logic [15:0]         stall
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic             lastWin;
  logic [CNT_W-1:0] holdCnt;
  logic             req0;
  logic             req1;
  logic             accept;
  logic             holdHit;

  assign req0    = r0ChipSelect & r0Write;
  assign req1    = r1ChipSelect & r1Write;
  assign accept  = ((state == OWN0) & req0 | (state == OWN1) & req1) & ~mWaitRequest;
  assign holdHit = ((5'(holdCnt) + 5'd1) >= 5'(MAX_HOLD));

  // State, round-robin pointer and hold counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      lastWin <= 1'b1;
      holdCnt <= '0;
    end else begin
      state <= stateNext;
      if ((stateNext != state) && (stateNext != IDLE)) begin
        holdCnt <= '0;
        lastWin <= (stateNext == OWN1);
      end else if (accept && (holdCnt != 4'hF)) begin
        holdCnt <= holdCnt + 4'd1;
      end
    end
  end

  // Next-state: a stalled owner transfer always blocks a switch
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  stateNext = lastWin ? OWN0 : OWN1;
        else if (req0)     stateNext = OWN0;
        else if (req1)     stateNext = OWN1;
      end
      OWN0: begin
        if (!req0)                                stateNext = req1 ? OWN1 : IDLE;
        else if (!mWaitRequest && holdHit && req1) stateNext = OWN1;
      end
      OWN1: begin
        if (!req1)                                stateNext = req0 ? OWN0 : IDLE;
        else if (!mWaitRequest && holdHit && req0) stateNext = OWN0;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath mux and waitrequest steering from the registered owner
  always_comb begin
    grant         = 2'b00;
    r0WaitRequest = 1'b1;
    r1WaitRequest = 1'b1;
    mAddress      = '0;
    mByteEnable   = '0;
    mChipSelect   = 1'b0;
    mWrite        = 1'b0;
    mWriteData    = '0;
    case (state)
      OWN0: begin
        grant         = 2'b01;
        r0WaitRequest = mWaitRequest;
        mAddress      = r0Address;
        mByteEnable   = r0ByteEnable;
        mChipSelect   = r0ChipSelect;
        mWrite        = r0Write;
        mWriteData    = r0WriteData;
      end
      OWN1: begin
        grant         = 2'b10;
        r1WaitRequest = mWaitRequest;
        mAddress      = r1Address;
        mByteEnable   = r1ByteEnable;
        mChipSelect   = r1ChipSelect;
        mWrite        = r1Write;
        mWriteData    = r1WriteData;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

`ifdef ARB_STATS_EN
  logic waiting;

  // A requester is waiting whenever it asserts a request it does not own
  assign waiting = (req0 && (state != OWN0)) || (req1 && (state != OWN1));

  // Saturating accept and stall counters
  always_ff @(posedge clock) begin
    if (reset) begin
      stat0 <= '0;
      stat1 <= '0;
      stall <= '0;
    end else begin
      if (accept && (state == OWN0) && (stat0 != 32'hFFFF_FFFF)) stat0 <= stat0 + 32'd1;
      if (accept && (state == OWN1) && (stat1 != 32'hFFFF_FFFF)) stat1 <= stat1 + 32'd1;
      if (waiting && (stall != 16'hFFFF))                        stall <= stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_avmm_wr_arbiter.sv
// Directed self-checking bench for avmm_wr_arbiter (MAX_HOLD=4).
module tb_avmm_wr_arbiter;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W/8;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] r0Address, r1Address, mAddress;
  logic [BE_W-1:0]   r0ByteEnable, r1ByteEnable, mByteEnable;
  logic              r0ChipSelect, r0Write, r0WaitRequest;
  logic              r1ChipSelect, r1Write, r1WaitRequest;
  logic [DATA_W-1:0] r0WriteData, r1WriteData, mWriteData;
  logic              mChipSelect, mWrite, mWaitRequest;
  logic [1:0]        grant;
`ifdef ARB_STATS_EN
  logic [31:0]       stat0, stat1;
  logic [15:0]       stall;
`endif

  int errCnt = 0;
  int chkCnt = 0;
  int acc0 = 0;
  int acc1 = 0;
  int snap0, snap1;

  avmm_wr_arbiter #(.MAX_HOLD(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .r0Address(r0Address), .r0ByteEnable(r0ByteEnable), .r0ChipSelect(r0ChipSelect),
    .r0Write(r0Write), .r0WriteData(r0WriteData), .r0WaitRequest(r0WaitRequest),
    .r1Address(r1Address), .r1ByteEnable(r1ByteEnable), .r1ChipSelect(r1ChipSelect),
    .r1Write(r1Write), .r1WriteData(r1WriteData), .r1WaitRequest(r1WaitRequest),
    .mAddress(mAddress), .mByteEnable(mByteEnable), .mChipSelect(mChipSelect),
    .mWrite(mWrite), .mWriteData(mWriteData), .mWaitRequest(mWaitRequest),
    .grant(grant)
`ifdef ARB_STATS_EN
    , .stat0(stat0), .stat1(stat1), .stall(stall)
`endif
  );

  always #5 clock = ~clock;

  // Accepted-transfer tally per requester, taken at the accepting edge
  always @(posedge clock) begin
    if (!reset && !mWaitRequest) begin
      if (grant == 2'b01 && r0ChipSelect && r0Write) acc0 <= acc0 + 1;
      if (grant == 2'b10 && r1ChipSelect && r1Write) acc1 <= acc1 + 1;
    end
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setReq0(input logic on);
    r0ChipSelect = on;
    r0Write      = on;
  endtask

  task automatic setReq1(input logic on);
    r1ChipSelect = on;
    r1Write      = on;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, ".grant"}, 64'(grant), 64'd0);
    checkVal({tag, ".r0Wait"}, 64'(r0WaitRequest), 64'd1);
    checkVal({tag, ".r1Wait"}, 64'(r1WaitRequest), 64'd1);
    checkVal({tag, ".mCS"}, 64'(mChipSelect), 64'd0);
    checkVal({tag, ".mWrite"}, 64'(mWrite), 64'd0);
    checkVal({tag, ".mAddr"}, mAddress, 64'd0);
    checkVal({tag, ".mData"}, 64'(mWriteData), 64'd0);
    checkVal({tag, ".mBE"}, 64'(mByteEnable), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    r0Address = '0; r0ByteEnable = '0; r0WriteData = '0;
    r1Address = '0; r1ByteEnable = '0; r1WriteData = '0;
    setReq0(1'b0);
    setReq1(1'b0);
    mWaitRequest = 1'b0;
    tick();
    tick();

    // Reset state, then idle with no requests
    checkResetOutputs("rst");
    reset = 1'b0;
    tick(); tick(); tick();
    checkVal("idleNoReq.grant", 64'(grant), 64'd0);

    // Requester 0 alone: three writes
    r0Address = 64'h0000_1000_0000_0000; r0WriteData = 32'hA000_0000; r0ByteEnable = 4'hF;
    setReq0(1'b1);
    checkVal("r0.grantLatency", 64'(grant), 64'd0);
    checkVal("r0.waitInIdle", 64'(r0WaitRequest), 64'd1);
    snap0 = acc0;
    tick();
    checkVal("r0.grant", 64'(grant), 64'd1);
    checkVal("r0.addr0", mAddress, 64'h0000_1000_0000_0000);
    checkVal("r0.data0", 64'(mWriteData), 64'hA000_0000);
    checkVal("r0.mWrite", 64'(mWrite), 64'd1);
    checkVal("r0.wait", 64'(r0WaitRequest), 64'd0);
    checkVal("r0.r1wait", 64'(r1WaitRequest), 64'd1);
    tick();
    r0Address = 64'h0000_1000_0000_0004; r0WriteData = 32'hA000_0001; r0ByteEnable = 4'h3;
    #1;
    checkVal("r0.addr1", mAddress, 64'h0000_1000_0000_0004);
    checkVal("r0.be1", 64'(mByteEnable), 64'h3);
    tick();
    r0Address = 64'h0000_1000_0000_0008; r0WriteData = 32'hA000_0002;
    #1;
    checkVal("r0.data2", 64'(mWriteData), 64'hA000_0002);
    tick();
    setReq0(1'b0);
    #1;
    checkVal("r0.dropGrant", 64'(grant), 64'd1);
    tick();
    checkVal("r0.accepts", 64'(acc0 - snap0), 64'd3);
    checkVal("r0.backIdle", 64'(grant), 64'd0);

    // Both continuous from a fresh reset: 4/4 alternation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    r0Address = 64'hA0; r1Address = 64'hB0;
    setReq0(1'b1);
    setReq1(1'b1);
    snap0 = acc0; snap1 = acc1;
    tick();
    for (int i = 0; i < 16; i++) begin
      checkVal($sformatf("rr.grant%0d", i), 64'(grant), ((i / 4) % 2 == 0) ? 64'd1 : 64'd2);
      checkVal($sformatf("rr.addr%0d", i), mAddress, ((i / 4) % 2 == 0) ? 64'hA0 : 64'hB0);
      tick();
    end
    checkVal("rr.acc0", 64'(acc0 - snap0), 64'd8);
    checkVal("rr.acc1", 64'(acc1 - snap1), 64'd8);
    setReq0(1'b0);
    setReq1(1'b0);
    tick();
    checkVal("rr.idle", 64'(grant), 64'd0);

    // Requester 1 owns through a 10-cycle downstream stall
    setReq1(1'b1);
    tick();
    checkVal("stall.own1", 64'(grant), 64'd2);
    setReq0(1'b1);
    mWaitRequest = 1'b1;
    snap1 = acc1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 0 || i == 9) begin
        checkVal($sformatf("stall.grant%0d", i), 64'(grant), 64'd2);
        checkVal($sformatf("stall.r1wait%0d", i), 64'(r1WaitRequest), 64'd1);
        checkVal($sformatf("stall.r0wait%0d", i), 64'(r0WaitRequest), 64'd1);
      end
      tick();
    end
    checkVal("stall.noAccept", 64'(acc1 - snap1), 64'd0);
    checkVal("stall.held", 64'(grant), 64'd2);
    mWaitRequest = 1'b0;
    #1;
    checkVal("stall.release", 64'(r1WaitRequest), 64'd0);
    tick();
    checkVal("stall.accepted", 64'(acc1 - snap1), 64'd1);
    checkVal("stall.keep", 64'(grant), 64'd2);

    // Owner drops with the other pending: direct handover both ways
    setReq1(1'b0);
    tick();
    checkVal("hand.1to0", 64'(grant), 64'd1);
    setReq1(1'b1);
    setReq0(1'b0);
    #1;
    checkVal("hand.dropCycle", 64'(grant), 64'd1);
    checkVal("hand.mCS", 64'(mChipSelect), 64'd0);
    tick();
    checkVal("hand.0to1", 64'(grant), 64'd2);

    // Reset mid-stall in OWN1, then requester 0 wins first
    setReq0(1'b1);
    mWaitRequest = 1'b1;
    tick();
    checkVal("midRst.pre", 64'(grant), 64'd2);
    reset = 1'b1;
    tick();
    checkResetOutputs("midRst");
`ifdef ARB_STATS_EN
    checkVal("midRst.stat0", 64'(stat0), 64'd0);
    checkVal("midRst.stat1", 64'(stat1), 64'd0);
    checkVal("midRst.stall", 64'(stall), 64'd0);
`endif
    reset = 1'b0;
    mWaitRequest = 1'b0;
    #1;
    checkVal("postRst.idle", 64'(grant), 64'd0);
    tick();
    checkVal("postRst.r0First", 64'(grant), 64'd1);

    // Six r0 accepts then two r1 accepts
    setReq1(1'b0);
    snap0 = acc0; snap1 = acc1;
    for (int i = 0; i < 6; i++) tick();
    setReq0(1'b0);
    setReq1(1'b1);
    tick();
    checkVal("cnt.own1", 64'(grant), 64'd2);
    tick(); tick();
    setReq1(1'b0);
    tick();
    checkVal("cnt.acc0", 64'(acc0 - snap0), 64'd6);
    checkVal("cnt.acc1", 64'(acc1 - snap1), 64'd2);
    checkVal("cnt.idle", 64'(grant), 64'd0);
`ifdef ARB_STATS_EN
    checkVal("cnt.stat0", 64'(stat0), 64'd6);
    checkVal("cnt.stat1", 64'(stat1), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkVal("cnt.stat0Clr", 64'(stat0), 64'd0);
    checkVal("cnt.stat1Clr", 64'(stat1), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
